spike_pushback_ctrl: RTL

SPIKE_PUSHBACK_CTRL -- requirements
Module: spike_pushback_ctrl

---
 rtl/spike_pushback_pkg.sv | 16 +
 rtl/spike_addr_fifo.sv | 70 +++++++
 rtl/spike_pushback_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spike_pushback_pkg.sv
// Shared FSM state encoding and default parameter values for the spike pushback controller.
package spike_pushback_pkg;

  localparam int DEF_M              = 8;
  localparam int DEF_INPUT_RESO     = 8;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_EARLY_STOP_THR = 245;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_TICK = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/spike_addr_fifo.sv
// Power-of-two circular FIFO for spike addresses; full+pop admits a push, flush empties it.
module spike_addr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spike_pushback_ctrl.sv
// Inference sequencer: issues ticks, buffers output spikes, stops early on a high address.
// Optional irq_o output is enabled by defining SPIKE_PUSHBACK_IRQ_EN.
module spike_pushback_ctrl
  import spike_pushback_pkg::*;
#(
  parameter int M              = DEF_M,
  parameter int INPUT_RESO     = DEF_INPUT_RESO,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int EARLY_STOP_THR = DEF_EARLY_STOP_THR
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [INPUT_RESO-1:0]         n_ticks_i,
  input  logic                          clear_i,
  output logic                          tick_req_o,
  input  logic                          tick_done_i,
  input  logic                          spike_i,
  input  logic [M-1:0]                  spike_addr_i,
  output logic                          rd_valid_o,
  output logic [M-1:0]                  rd_addr_o,
  input  logic                          rd_ready_i,
  output logic                          busy_o,
  output logic                          inference_done_o,
  output logic                          early_stop_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef SPIKE_PUSHBACK_IRQ_EN
  ,
  output logic                          irq_o
`endif
);

  localparam logic [31:0] THR = EARLY_STOP_THR;

  state_e                state_q, state_d;
  logic [INPUT_RESO-1:0] remaining_q, remaining_d;
  logic                  early_stop_q, early_stop_d;
  logic                  overflow_q, overflow_d;
  logic                  tick_req_q, busy_q, done_q;

  logic fifo_full, fifo_empty;
  logic active, push, pop, big_spike;

  assign active    = (state_q == ST_RUN) || (state_q == ST_WAIT_TICK);
  assign pop       = !fifo_empty && rd_ready_i;
  assign push      = spike_i && active && !clear_i;
  assign big_spike = spike_i && (32'(spike_addr_i) > THR);

  spike_addr_fifo #(
    .W     (M),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (spike_addr_i),
    .head_o  (rd_addr_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    early_stop_d = early_stop_q;
    overflow_d   = overflow_q;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            if (n_ticks_i == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d      = ST_RUN;
              remaining_d  = n_ticks_i;
              early_stop_d = 1'b0;
              overflow_d   = 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (tick_done_i) remaining_d = remaining_q - 1'b1;
          // A tick already completing alongside the stop spike leaves nothing in flight.
          if (big_spike) begin
            early_stop_d = 1'b1;
            state_d      = tick_done_i ? ST_DONE : ST_WAIT_TICK;
          end else if (tick_done_i && remaining_q == INPUT_RESO'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_WAIT_TICK: begin
          if (tick_done_i) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef SPIKE_PUSHBACK_IRQ_EN
  logic irq_q, irq_d;
  always_comb begin
    irq_d = ((state_d == ST_DONE) && (state_q != ST_DONE)) || (overflow_d && !overflow_q);
  end
  assign irq_o = irq_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      early_stop_q <= 1'b0;
      overflow_q   <= 1'b0;
      tick_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SPIKE_PUSHBACK_IRQ_EN
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      early_stop_q <= early_stop_d;
      overflow_q   <= overflow_d;
      tick_req_q   <= (state_d == ST_RUN);
      busy_q       <= (state_d == ST_RUN) || (state_d == ST_WAIT_TICK);
      done_q       <= (state_d == ST_DONE);
`ifdef SPIKE_PUSHBACK_IRQ_EN
      irq_q        <= irq_d;
`endif
    end
  end

  assign tick_req_o       = tick_req_q;
  assign busy_o           = busy_q;
  assign inference_done_o = done_q;
  assign early_stop_o     = early_stop_q;
  assign overflow_o       = overflow_q;
  assign rd_valid_o       = !fifo_empty;

endmodule
